// File: rtl/skid_buff_pkg.sv
// Shared types and defaults for the skid_buff register slice.
package skid_buff_pkg;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/dti.sv
// DTI link: data plus valid/ready handshake. A transfer completes on a
// rising edge where valid and ready are both high.
interface dti #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/skid_buff.sv
// skid_buff: full-throughput two-entry DTI register slice. Both dout.valid
// and din.ready come straight from the state flop, so neither direction has
// a combinational path through the slice. A second "skid" entry absorbs the
// word that arrives during the cycle it takes din.ready to drop.
// Optional feature: define SKID_BUFF_STALL_CNT_EN to add the saturating
// stall_cnt output that counts cycles with dout.valid & !dout.ready.
module skid_buff
  import skid_buff_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  dti.consumer             din,
  dti.producer             dout
`ifdef SKID_BUFF_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int W = $bits(dout.data);

  if ($bits(din.data) != $bits(dout.data)) begin : g_width_chk
    $error("skid_buff: din.data and dout.data widths differ");
  end

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("skid_buff: CNT_W must be at least 1");
  end

  skid_state_t  state_q, state_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;

  assign din.ready  = (state_q != FULL);
  assign dout.valid = (state_q != EMPTY);
  assign dout.data  = out_data_q;

  // Next state and data loads; the skid entry is always drained into the
  // output register before any newer din word, keeping strict FIFO order.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (din.valid) begin
          out_data_d = din.data;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (din.valid && dout.ready) begin
          out_data_d = din.data;
        end else if (din.valid) begin
          skid_data_d = din.data;
          state_d     = FULL;
        end else if (dout.ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (dout.ready) begin
          out_data_d = skid_data_q;
          state_d    = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Control state: reset discards both entries.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Data registers: no reset, contents are don't-care while their entry is invalid.
  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

`ifdef SKID_BUFF_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count output stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                            stall_cnt_q <= '0;
    else if (dout.valid && !dout.ready) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skid_buff.sv
// Testbench for skid_buff: directed timing checks plus randomized traffic
// checked by a FIFO scoreboard in a separate monitor process.
module tb_skid_buff;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dti #(.W(8)) din_if  ();
  dti #(.W(8)) dout_if ();

`ifdef SKID_BUFF_STALL_CNT_EN
  logic [3:0] stall_cnt;
`endif

  skid_buff #(.CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
`ifdef SKID_BUFF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, then record any
  // input handshake that the following rising edge will complete.
  task automatic drive(input logic v, input logic [7:0] d, input logic r, output bit acc);
    @(negedge clk);
    din_if.valid  = v;
    din_if.data   = d;
    dout_if.ready = r;
    #1;
    acc = (!rst && v && din_if.ready);
    if (acc) exp_q.push_back(d);
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks that a
  // stalled output word stays put.
  initial begin
    bit         prev_stall = 0;
    logic [7:0] prev_data  = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {31'b0, dout_if.valid}, 32'd1);
          check("hold_data", {24'b0, dout_if.data}, {24'b0, prev_data});
        end
        if (dout_if.valid && dout_if.ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got %0h, expected no output", dout_if.data);
          end else begin
            e = exp_q.pop_front();
            check("order", {24'b0, dout_if.data}, {24'b0, e});
          end
        end
        prev_stall = dout_if.valid && !dout_if.ready;
        prev_data  = dout_if.data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    bit         pending;
    logic [7:0] cur;
    logic [7:0] t1 [3];
    int         sent;
    int         cyc;

    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout_valid", {31'b0, dout_if.valid}, 32'd0);
    check("rst_din_ready", {31'b0, din_if.ready}, 32'd1);
    rst = 1'b0;

    // Streaming at full rate: each word visible the cycle after acceptance
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t1[i], 1'b1, acc);
      check("t1_accept", {31'b0, acc}, 32'd1);
      if (i > 0) begin
        check("t1_valid", {31'b0, dout_if.valid}, 32'd1);
        check("t1_data", {24'b0, dout_if.data}, {24'b0, t1[i-1]});
      end
    end
    drive(1'b0, 8'h00, 1'b1, acc);
    check("t1_last_data", {24'b0, dout_if.data}, 32'h33);
    drive(1'b0, 8'h00, 1'b1, acc);
    check("t1_idle_valid", {31'b0, dout_if.valid}, 32'd0);

    // Backpressure: skid absorbs A1, din.ready drops, then recovers
    drive(1'b1, 8'hA0, 1'b0, acc);
    drive(1'b1, 8'hA1, 1'b0, acc);
    check("bp_a1_accept", {31'b0, acc}, 32'd1);
    drive(1'b1, 8'hA2, 1'b0, acc);
    check("bp_full_ready", {31'b0, din_if.ready}, 32'd0);
    check("bp_head", {24'b0, dout_if.data}, 32'hA0);
    drive(1'b1, 8'hA2, 1'b0, acc);
    check("bp_full_hold", {31'b0, din_if.ready}, 32'd0);
    drive(1'b1, 8'hA2, 1'b1, acc);
    check("bp_no_accept_full", {31'b0, acc}, 32'd0);
    drive(1'b1, 8'hA2, 1'b1, acc);
    check("bp_ready_back", {31'b0, din_if.ready}, 32'd1);
    check("bp_a1_out", {24'b0, dout_if.data}, 32'hA1);
    drive(1'b0, 8'h00, 1'b1, acc);
    check("bp_a2_out", {24'b0, dout_if.data}, 32'hA2);
    drive(1'b0, 8'h00, 1'b1, acc);

    // Randomized traffic, 1000 words
    sent    = 0;
    cyc     = 0;
    pending = 0;
    cur     = '0;
    while (sent < 1000 && cyc < 20000) begin
      if (!pending && $urandom_range(0, 1) == 1) begin
        cur     = 8'($urandom);
        pending = 1;
      end
      drive(pending, cur, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        pending = 0;
        sent++;
      end
      cyc++;
    end
    check("rand_words_sent", sent, 1000);
    for (int k = 0; k < 6; k++) drive(1'b0, 8'h00, 1'b1, acc);
    check("rand_drained", exp_q.size(), 0);

    // Reset while FULL: both entries dropped, no stale word afterwards
    drive(1'b1, 8'hB0, 1'b0, acc);
    drive(1'b1, 8'hB1, 1'b0, acc);
    drive(1'b1, 8'hB2, 1'b0, acc);
    check("rf_full", {31'b0, din_if.ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    din_if.valid  = 1'b0;
    dout_if.ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rf_dout_valid", {31'b0, dout_if.valid}, 32'd0);
    check("rf_din_ready", {31'b0, din_if.ready}, 32'd1);
    for (int k = 0; k < 4; k++) drive(1'b0, 8'h00, 1'b1, acc);

`ifdef SKID_BUFF_STALL_CNT_EN
    // Stall counter saturates at 15 with a 4-bit width, clears on reset
    drive(1'b1, 8'hC0, 1'b0, acc);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 8'h00, 1'b0, acc);
      check("stall_cnt_ramp", {28'b0, stall_cnt}, (k - 1 > 15) ? 15 : k - 1);
    end
    drive(1'b0, 8'h00, 1'b1, acc);
    check("stall_cnt_sat", {28'b0, stall_cnt}, 32'd15);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stall_cnt_rst", {28'b0, stall_cnt}, 32'd0);
`endif

    for (int k = 0; k < 3; k++) drive(1'b0, 8'h00, 1'b1, acc);
    check("final_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
